// File: rtl/bcd_dabble_converter.sv
`timescale 1ns/1ps
// bcd_dabble_converter
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
//
// Parameters:
//   BIN_WIDTH - width of the unsigned binary input (>= 1)
//   DIGITS    - number of BCD digits produced (>= 1)
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - synchronous active-low reset
//   start    - conversion request, sampled only while idle
//   bin      - value to convert, sampled on the accepting edge
//   busy     - high while a conversion is in progress
//   done     - one-cycle pulse when bcd/overflow are updated
//   bcd      - packed result, digit i at [4i+3:4i], digit 0 least significant
//   overflow - last converted value was >= 10^DIGITS
module bcd_dabble_converter #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state;
    logic [BIN_WIDTH-1:0]   shift_q;
    logic [4*DIGITS-1:0]    scratch_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;

    logic [4*DIGITS-1:0]    adjusted;
    logic [4*DIGITS-1:0]    scratch_next;
    logic                   ovf_next;

    // Per-digit add-3 correction, then the shift. The carry leaving the top
    // digit would be worth 10^DIGITS, so dropping it yields the value modulo
    // 10^DIGITS while the sticky flag records that it ever happened.
    always_comb begin
        adjusted = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {adjusted[4*DIGITS-2:0], shift_q[BIN_WIDTH-1]};
        ovf_next     = ovf_q | adjusted[4*DIGITS-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q   <= shift_q << 1;
                    scratch_q <= scratch_next;
                    ovf_q     <= ovf_next;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SHIFT) begin
                        bcd      <= scratch_next;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bcd_dabble_converter.md
# bcd_dabble_converter

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits between the up/down/load counter and the seven-segment driver. It accepts a binary count on a start strobe and returns packed BCD digits. The result is held stable so the display scan logic can split it into per-digit 4-bit fields. It replaces a wide combinational converter with a small, fixed-latency datapath and adds an explicit overflow indication.

## Interface
Parameters:
- BIN_WIDTH, 8, width of the unsigned binary input; must be ≥ 1.
- DIGITS, 3, number of BCD digits produced; must be ≥ 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- start  input  1  request to convert `bin`; sampled only in IDLE.
- bin  input  BIN_WIDTH  unsigned value to convert; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; `bcd` and `overflow` are valid and updated in that cycle.
- bcd  output  4*DIGITS  result, digit i at bits [4i+3:4i]; digit 0 is the least significant.
- overflow  output  1  high when the last converted value was ≥ 10^DIGITS.

## Operation
- The state machine has two states: IDLE and SHIFT.
- IDLE with start=1 at an edge:
  - the shift register is loaded with `bin`;
  - the scratch BCD register is cleared;
  - the bit counter is set to 0;
  - the overflow scratch flag is cleared;
  - busy goes to 1;
  - the state moves to SHIFT.
- IDLE with start=0: no state change; outputs hold.
- Each SHIFT edge performs these steps in order:
  - every scratch digit ≥ 5 has 3 added (per digit, 4-bit, no inter-digit carry);
  - the combined {scratch, shift register} is shifted left by 1;
  - the bit leaving the top of the scratch register is ORed into the overflow scratch flag;
  - the counter increments.
- On the edge that performs shift number BIN_WIDTH:
  - `bcd` takes the post-shift scratch value;
  - `overflow` takes the post-shift scratch flag;
  - done=1 and busy=0;
  - the state moves to IDLE.
- done is held high for exactly one cycle and returns to 0 on the next edge.
- Arithmetic: `bcd` = bin mod 10^DIGITS. `overflow` = (bin ≥ 10^DIGITS). Both hold exactly for all BIN_WIDTH and DIGITS.
- start while busy=1 is ignored and not queued. Changes on `bin` while busy have no effect.
- `bcd` and `overflow` hold their last result until the next done. They are never driven with intermediate values.
- The bit counter is $clog2(BIN_WIDTH+1) bits wide; BIN_WIDTH=1 is legal.

## Timing
- Reset values: busy=0, done=0, bcd=0, overflow=0, state=IDLE; the scratch registers and counter are cleared.
- Reset applies at any edge where reset_n=0 and overrides start. A conversion in progress is abandoned with no done pulse.
- Latency: start is accepted at edge E0; done=1 and the new `bcd` are visible in the cycle after edge E0+BIN_WIDTH.
- Throughput:
  - busy is high for exactly BIN_WIDTH cycles;
  - start high in the done cycle is accepted, since the state is IDLE;
  - back-to-back conversions therefore occur every BIN_WIDTH+1 cycles.
- Holding start high continuously gives a free-running conversion. Each conversion samples `bin` on its own accepting edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Default parameters, bin=8'd255, start pulsed 1 cycle:
  - busy is high 8 cycles;
  - done pulses 8 cycles after acceptance;
  - bcd=12'h255, overflow=0.
- Exhaustive sweep, default parameters, bin 0..255, each value converted once:
  - bcd equals the decimal digits of bin;
  - overflow=0 throughout;
  - bin=0 gives 12'h000 and bin=99 gives 12'h099.
- Busy interlock, default parameters:
  - start bin=8'd200, then at cycle 3 pulse start with bin=8'd17;
  - exactly one done, with bcd=12'h200;
  - with start held high, a new acceptance occurs in the done cycle and bin=8'd17 converts to 12'h017 nine cycles after the first.
- Reset mid-conversion:
  - start bin=8'd128, then reset_n=0 for 1 cycle at cycle 4;
  - busy=0, done=0, bcd=0 with no done pulse afterwards;
  - a following start with bin=8'd42 gives 12'h042.
- Overflow with BIN_WIDTH=10, DIGITS=3:
  - bin=1023 gives bcd=12'h023, overflow=1, latency 10;
  - a next conversion with bin=999 gives bcd=12'h999 and clears overflow to 0.
- Reset values: reset_n low for 3 cycles with start=1 throughout; all outputs stay 0 and no conversion starts.
